// File: rtl/hazard_pkg.sv
// Shared types and defaults for the N-lane hazard controller.
package hazard_pkg;

  localparam int N_LANE_DEF     = 2;
  localparam int REG_AW_DEF     = 5;
  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic ena;
    logic flush;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_RUN   = '{ena: 1'b1, flush: 1'b0};
  localparam stage_ctl_t CTL_RESET = '{ena: 1'b1, flush: 1'b1};

endpackage

// File: rtl/hazard_div_timer.sv
// Divider occupancy timer: counts down the busy window of a multi-cycle divide.
//   state | meaning
//   IDLE  | no divide in flight; start launches one
//   BUSY  | divide running, cnt counts remaining busy cycles down to 1
//   DONE  | single cycle where E captures the quotient
module hazard_div_timer
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  input  logic kill,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(DIV_CYCLES);
  // The start cycle already stalls once, so BUSY lasts DIV_CYCLES-1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        BUSY: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CW'(1)) state_nxt = DONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Per-stage enable/flush generation for an N-lane in-order pipeline:
// exception, memory wait, divider, load-use and branch handling in priority order.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int N_LANE     = N_LANE_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_LANE*REG_AW-1:0] D_rs,
  input  logic [N_LANE*REG_AW-1:0] D_rt,
  input  logic [N_LANE-1:0]        E_memtoReg,
  input  logic [N_LANE*REG_AW-1:0] E_reg_waddr,
  input  logic                     E_branch_taken,
  input  logic                     E_div_start,
  input  logic                     M_dmem_stall,
  input  logic                     M_exception,
  output logic                     F_ena,
  output logic                     D_ena,
  output logic                     E_ena,
  output logic                     M_ena,
  output logic                     W_ena,
  output logic                     F_flush,
  output logic                     D_flush,
  output logic                     E_flush,
  output logic                     M_flush,
  output logic                     W_flush,
  output logic                     E_div_busy
);

  logic [N_LANE*N_LANE-1:0] lw_hit;
  logic lwstall, divstall, branch;
  logic div_busy, div_done;
  logic br_pend, br_pend_nxt;
  stage_ctl_t ctl_f, ctl_d, ctl_e, ctl_m, ctl_w;

  // Every D lane against every E lane; a load to $0 never creates a dependency.
  for (genvar i = 0; i < N_LANE; i++) begin : g_d
    for (genvar j = 0; j < N_LANE; j++) begin : g_e
      logic [REG_AW-1:0] rs, rt, wa;
      assign rs = D_rs[i*REG_AW +: REG_AW];
      assign rt = D_rt[i*REG_AW +: REG_AW];
      assign wa = E_reg_waddr[j*REG_AW +: REG_AW];
      assign lw_hit[i*N_LANE+j] = E_memtoReg[j] & (wa != '0) & ((rs == wa) | (rt == wa));
    end
  end

  assign lwstall = |lw_hit;

  hazard_div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk  (clk),
    .rst  (rst),
    .start(E_div_start),
    .hold (M_dmem_stall),
    .kill (M_exception),
    .busy (div_busy),
    .done (div_done)
  );

  assign divstall   = div_busy | (!div_busy & !div_done & E_div_start);
  assign branch     = E_branch_taken | br_pend;
  assign E_div_busy = div_busy;

  always_ff @(posedge clk) begin
    if (rst) br_pend <= 1'b0;
    else     br_pend <= br_pend_nxt;
  end

  always_comb begin
    ctl_f       = CTL_RUN;
    ctl_d       = CTL_RUN;
    ctl_e       = CTL_RUN;
    ctl_m       = CTL_RUN;
    ctl_w       = CTL_RUN;
    br_pend_nxt = br_pend;
    if (rst) begin
      ctl_f = CTL_RESET;
      ctl_d = CTL_RESET;
      ctl_e = CTL_RESET;
      ctl_m = CTL_RESET;
      ctl_w = CTL_RESET;
    end else if (M_exception) begin
      ctl_f.flush = 1'b1;
      ctl_d.flush = 1'b1;
      ctl_e.flush = 1'b1;
      ctl_m.flush = 1'b1;
      br_pend_nxt = 1'b0;
    end else if (M_dmem_stall) begin
      ctl_f.ena   = 1'b0;
      ctl_d.ena   = 1'b0;
      ctl_e.ena   = 1'b0;
      ctl_m.ena   = 1'b0;
      ctl_w.flush = 1'b1;
      if (E_branch_taken) br_pend_nxt = 1'b1;
    end else if (divstall) begin
      ctl_f.ena   = 1'b0;
      ctl_d.ena   = 1'b0;
      ctl_e.ena   = 1'b0;
      ctl_m.flush = 1'b1;
      if (E_branch_taken) br_pend_nxt = 1'b1;
    end else begin
      // Load-use and branch can coexist: the branch flush kills the stalled D instruction.
      if (lwstall) begin
        ctl_f.ena   = 1'b0;
        ctl_d.ena   = 1'b0;
        ctl_e.flush = 1'b1;
      end
      if (branch) begin
        ctl_d.flush = 1'b1;
        ctl_e.flush = 1'b1;
        br_pend_nxt = 1'b0;
      end
    end
  end

  assign {F_ena, F_flush} = ctl_f;
  assign {D_ena, D_flush} = ctl_d;
  assign {E_ena, E_flush} = ctl_e;
  assign {M_ena, M_flush} = ctl_m;
  assign {W_ena, W_flush} = ctl_w;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal cases plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int NL = 2;
  localparam int DC = 4;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NL*AW-1:0] D_rs = '0, D_rt = '0, E_reg_waddr = '0;
  logic [NL-1:0]    E_memtoReg = '0;
  logic E_branch_taken = 1'b0, E_div_start = 1'b0, M_dmem_stall = 1'b0, M_exception = 1'b0;
  logic F_ena, D_ena, E_ena, M_ena, W_ena;
  logic F_flush, D_flush, E_flush, M_flush, W_flush;
  logic E_div_busy;
  logic [10:0] obs, exp_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: busy cycles still owed by the divider, result-capture cycle, held branch.
  int m_left = 0;
  bit m_done = 1'b0;
  bit m_pend = 1'b0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.N_LANE(NL), .DIV_CYCLES(DC), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .D_rs(D_rs), .D_rt(D_rt), .E_memtoReg(E_memtoReg), .E_reg_waddr(E_reg_waddr),
    .E_branch_taken(E_branch_taken), .E_div_start(E_div_start),
    .M_dmem_stall(M_dmem_stall), .M_exception(M_exception),
    .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena), .M_ena(M_ena), .W_ena(W_ena),
    .F_flush(F_flush), .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush),
    .E_div_busy(E_div_busy)
  );

  assign obs = {E_div_busy, F_ena, D_ena, E_ena, M_ena, W_ena,
                F_flush, D_flush, E_flush, M_flush, W_flush};

  function automatic bit model_lw();
    logic [AW-1:0] rs, rt, wa;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++) begin
        rs = D_rs[i*AW +: AW];
        rt = D_rt[i*AW +: AW];
        wa = E_reg_waddr[j*AW +: AW];
        if (E_memtoReg[j] && wa != 0 && (rs == wa || rt == wa)) hit = 1'b1;
      end
    return hit;
  endfunction

  function automatic bit model_divstall();
    return (m_left > 0) || (m_left == 0 && !m_done && E_div_start);
  endfunction

  // {busy, ena F..W, flush F..W}
  function automatic logic [10:0] model_out();
    bit [4:0] en, fl;
    bit busy;
    busy = (m_left > 0);
    en = 5'b11111;
    fl = 5'b00000;
    if (rst) fl = 5'b11111;
    else if (M_exception) fl = 5'b11110;
    else if (M_dmem_stall) begin en = 5'b00001; fl = 5'b00001; end
    else if (model_divstall()) begin en = 5'b00011; fl = 5'b00010; end
    else begin
      if (model_lw()) begin en = 5'b00111; fl = 5'b00100; end
      if (E_branch_taken || m_pend) fl = fl | 5'b01100;
    end
    return {busy, en, fl};
  endfunction

  always @(posedge clk) begin
    bit ds, frozen;
    started = 1'b1;
    cyc++;
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_pend = 1'b0;
    end else begin
      ds = model_divstall();
      frozen = M_dmem_stall || ds;
      if (M_exception) m_pend = 1'b0;
      else if (frozen && E_branch_taken) m_pend = 1'b1;
      else if (!frozen && (E_branch_taken || m_pend)) m_pend = 1'b0;
      if (M_exception) begin
        m_left = 0; m_done = 1'b0;
      end else if (!M_dmem_stall) begin
        if (m_done) m_done = 1'b0;
        else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end else if (E_div_start) m_left = DC - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_v = model_out();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL model cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [10:0] want);
    #2;
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, obs, want);
    end
  endtask

  task automatic clr();
    D_rs = '0; D_rt = '0; E_reg_waddr = '0; E_memtoReg = '0;
    E_branch_taken = 1'b0; E_div_start = 1'b0; M_dmem_stall = 1'b0; M_exception = 1'b0;
  endtask

  localparam logic [10:0] RUN   = 11'b0_11111_00000;
  localparam logic [10:0] RSTO  = 11'b0_11111_11111;
  localparam logic [10:0] DSTRT = 11'b0_00011_00010;
  localparam logic [10:0] DBUSY = 11'b1_00011_00010;
  localparam logic [10:0] BRF   = 11'b0_11111_01100;

  initial begin
    tick();
    lit("reset", RSTO);
    rst = 1'b0; clr();
    lit("idle", RUN);
    tick();

    // load in E lane1 to r8, D lane0 reads r8
    D_rs = {5'd0, 5'd8}; E_memtoReg = 2'b10; E_reg_waddr = {5'd8, 5'd0};
    lit("lw_cross", 11'b0_00111_00100);
    tick(); clr();
    lit("lw_after", RUN);
    tick();
    // $0 destination never stalls
    E_memtoReg = 2'b01; E_reg_waddr = '0; D_rs = '0; D_rt = '0;
    lit("lw_zero", RUN);
    tick(); clr();
    D_rt = {5'd3, 5'd0}; E_memtoReg = 2'b01; E_reg_waddr = {5'd0, 5'd3};
    lit("lw_rt_lane1", 11'b0_00111_00100);
    E_branch_taken = 1'b1;
    lit("lw_branch", 11'b0_00111_01100);
    tick(); clr();
    lit("lw_branch_nopend", RUN);
    tick();

    // full divide
    E_div_start = 1'b1;
    lit("div_start", DSTRT);
    tick(); E_div_start = 1'b0;
    for (int k = 0; k < DC - 1; k++) begin
      lit("div_busy", DBUSY);
      tick();
    end
    lit("div_done", RUN);
    tick();
    lit("div_idle", RUN);
    tick();

    // memory wait freezes divider mid-flight
    E_div_start = 1'b1;
    lit("div4_start", DSTRT);
    tick(); E_div_start = 1'b0;
    lit("div4_busy", DBUSY);
    tick();
    M_dmem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lit("div4_dmem", 11'b1_00001_00001);
      tick();
    end
    M_dmem_stall = 1'b0;
    for (int k = 0; k < DC - 2; k++) begin
      lit("div4_resume", DBUSY);
      tick();
    end
    lit("div4_done", RUN);
    tick();

    // branch held across a memory wait
    M_dmem_stall = 1'b1; E_branch_taken = 1'b1;
    lit("br_dmem", 11'b0_00001_00001);
    tick(); clr();
    lit("br_pend_apply", BRF);
    tick();
    lit("br_pend_clear", RUN);
    tick();

    // branch held across a divide, applied on the DONE cycle
    E_div_start = 1'b1; E_branch_taken = 1'b1;
    lit("br_div_start", DSTRT);
    tick(); clr();
    for (int k = 0; k < DC - 1; k++) begin
      lit("br_div_busy", DBUSY);
      tick();
    end
    lit("br_div_apply", BRF);
    tick();
    lit("br_div_clear", RUN);
    tick();

    // exception clears a pending branch
    M_dmem_stall = 1'b1; E_branch_taken = 1'b1;
    tick(); clr();
    M_exception = 1'b1;
    lit("exc_pend", 11'b0_11111_11110);
    tick(); clr();
    lit("exc_pend_gone", RUN);
    tick();

    // exception in BUSY with a load-use present
    E_div_start = 1'b1;
    tick(); clr();
    M_exception = 1'b1;
    D_rs = {5'd0, 5'd8}; E_memtoReg = 2'b10; E_reg_waddr = {5'd8, 5'd0};
    lit("exc_busy", 11'b1_11111_11110);
    tick(); clr();
    lit("exc_idle", RUN);
    tick();

    // reset mid-BUSY aborts with no DONE
    E_div_start = 1'b1;
    tick(); clr();
    lit("rst_busy_pre", DBUSY);
    rst = 1'b1;
    lit("rst_busy", 11'b1_11111_11111);
    tick(); rst = 1'b0;
    lit("rst_after", RUN);
    tick();
    lit("rst_nodone", RUN);
    tick();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int l = 0; l < NL; l++) begin
        D_rs[l*AW +: AW]        = AW'($urandom_range(0, 3));
        D_rt[l*AW +: AW]        = AW'($urandom_range(0, 3));
        E_reg_waddr[l*AW +: AW] = AW'($urandom_range(0, 3));
      end
      E_memtoReg     = NL'($urandom_range(0, (1 << NL) - 1));
      E_branch_taken = ($urandom_range(0, 99) < 20);
      E_div_start    = ($urandom_range(0, 99) < 8);
      M_dmem_stall   = ($urandom_range(0, 99) < 15);
      M_exception    = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
